// File: rtl/imm_enc_pkg.sv
// Shared encoding constants for the immediate encoder, the core immediate
// decoder and the control unit, plus the request record carried through
// the encoder pipeline.
package imm_enc_pkg;

  // extOP format selector values
  localparam logic [2:0] EXT_I   = 3'b000;
  localparam logic [2:0] EXT_U   = 3'b001;
  localparam logic [2:0] EXT_S   = 3'b010;
  localparam logic [2:0] EXT_B   = 3'b011;
  localparam logic [2:0] EXT_J   = 3'b100;
  localparam logic [2:0] EXT_ISH = 3'b101;
  localparam logic [2:0] EXT_RSV = 3'b110;
  localparam logic [2:0] EXT_R   = 3'b111;

  // RV32 major opcodes used by the self-test generator
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // One encode request as captured by the first pipeline stage
  typedef struct packed {
    logic [2:0]  ext_op;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } enc_req_t;

  // True when v is the sign extension of its low 'bits' bits, i.e. every
  // bit from bits-1 upward equals the sign bit.
  function automatic logic fits_signed(input logic signed [31:0] v,
                                       input int unsigned bits);
    logic signed [31:0] hi;
    hi = v >>> (bits - 1);
    return (hi == 32'sd0) || (hi == -32'sd1);
  endfunction

endpackage

// File: rtl/imm_enc_if.sv
// Request/response bundle of the immediate encoder. The master side is the
// instruction generator; the slave side is the encoder.
interface imm_enc_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_extOP;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport master (
    output in_valid, in_extOP, in_opcode, in_rd, in_funct3,
           in_rs1, in_rs2, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_extOP, in_opcode, in_rd, in_funct3,
           in_rs1, in_rs2, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/imm_enc_pack.sv
// Combinational field packer: checks that the immediate is representable
// in the selected format and scatters the fields into an RV32 word.
// Unrepresentable immediates and the reserved format yield a zero word.
module imm_pack
  import imm_enc_pkg::*;
(
  input  enc_req_t    req,
  output logic [31:0] instr,
  output logic        ok
);

  logic signed [31:0] imm_s;
  logic [31:0]        imm;
  logic [31:0]        word;

  assign imm   = req.imm;
  assign imm_s = signed'(req.imm);

  // Per-format representability check and bit placement
  always_comb begin
    ok   = 1'b0;
    word = 32'h0;
    case (req.ext_op)
      EXT_I: begin
        ok   = fits_signed(imm_s, 12);
        word = {imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
      end
      EXT_U: begin
        ok   = (imm[11:0] == 12'h0);
        word = {imm[31:12], req.rd, req.opcode};
      end
      EXT_S: begin
        ok   = fits_signed(imm_s, 12);
        word = {imm[11:5], req.rs2, req.rs1, req.funct3, imm[4:0], req.opcode};
      end
      EXT_B: begin
        ok   = !imm[0] && fits_signed(imm_s, 13);
        word = {imm[12], imm[10:5], req.rs2, req.rs1, req.funct3,
                imm[4:1], imm[11], req.opcode};
      end
      EXT_J: begin
        ok   = !imm[0] && fits_signed(imm_s, 21);
        word = {imm[20], imm[10:1], imm[11], imm[19:12], req.rd, req.opcode};
      end
      EXT_ISH: begin
        // shamt only; upper immediate bits come from funct7
        ok   = (imm[31:5] == 27'h0);
        word = {req.funct7, imm[4:0], req.rs1, req.funct3, req.rd, req.opcode};
      end
      EXT_R: begin
        ok   = 1'b1;
        word = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
      end
      default: begin
        ok   = 1'b0;
        word = 32'h0;
      end
    endcase
    instr = ok ? word : 32'h0;
  end

endmodule

// File: rtl/imm_enc.sv
// Immediate encoder: two-stage valid/ready pipeline turning decoded fields
// plus an immediate into an RV32 instruction word, with a saturating count
// of errored results accepted downstream.
module imm_enc
  import imm_enc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  imm_enc_if.slave         bus,
  output logic [CNT_W-1:0] err_cnt
);

  enc_req_t    req_in;
  enc_req_t    req_p1;
  logic        vld_p1;
  logic        vld_p2;
  logic [31:0] instr_p2;
  logic        err_p2;
  logic [31:0] pack_instr;
  logic        pack_ok;
  logic        s1_rdy;
  logic        s2_rdy;
  logic        out_fire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign req_in = '{ext_op: bus.in_extOP, opcode: bus.in_opcode,
                    rd: bus.in_rd, funct3: bus.in_funct3, rs1: bus.in_rs1,
                    rs2: bus.in_rs2, funct7: bus.in_funct7, imm: bus.in_imm};

  // Stage readiness only looks at registered valids and out_ready, so
  // in_valid never reaches out_valid combinationally.
  assign s2_rdy       = !vld_p2 || bus.out_ready;
  assign s1_rdy       = !vld_p1 || s2_rdy;
  assign bus.in_ready = s1_rdy;
  assign out_fire     = vld_p2 && bus.out_ready;

  // ---- stage 1: captured request fields ----
  // S1 valid tracks acceptance whenever the stage is free to move
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (s1_rdy) begin
      vld_p1 <= bus.in_valid;
    end
  end

  // S1 fields load on every accepted request
  always_ff @(posedge clk) begin
    if (s1_rdy && bus.in_valid) begin
      req_p1 <= req_in;
    end
  end

  imm_pack u_pack (
    .req   (req_p1),
    .instr (pack_instr),
    .ok    (pack_ok)
  );

  // ---- stage 2: packed word and error flag ----
  // S2 advances when empty or drained; held values stay stable on stall
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2   <= 1'b0;
      instr_p2 <= 32'h0;
      err_p2   <= 1'b0;
    end else if (s2_rdy) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        instr_p2 <= pack_instr;
        err_p2   <= !pack_ok;
      end
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.out_instr = instr_p2;
  assign bus.out_err   = err_p2;

  // Count errored results as they leave, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (out_fire && err_p2) begin
      err_cnt <= sat_inc(err_cnt);
    end
  end

endmodule

// File: tb/tb_imm_enc.sv
// Self-checking bench for imm_enc: directed cases, backpressure, reset
// mid-operation, randomized traffic with a behavioural encoder/decoder
// model, and error counter saturation.
module tb_imm_enc;
  import imm_enc_pkg::*;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic [CNT_W-1:0] err_cnt;

  imm_enc_if bus ();

  imm_enc #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [2:0]  ext;
    logic [6:0]  f7;
    logic [31:0] imm;
  } exp_t;

  exp_t        q[$];
  int unsigned model_cnt = 0;
  logic        hold = 1'b0;
  logic [31:0] held_instr;
  logic        held_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sx(input logic [31:0] v, input int n);
    logic [31:0] m;
    m = 32'h1 << (n - 1);
    return (v ^ m) - m;
  endfunction

  // Reference encoder: range-based representability, arithmetic placement
  function automatic logic [32:0] model_enc(input logic [2:0] ext, input logic [6:0] op,
      input logic [4:0] rd, input logic [2:0] f3, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [6:0] f7, input logic [31:0] imm);
    longint s;
    logic ok;
    logic [31:0] w;
    logic [31:0] base;
    s = longint'($signed(imm));
    base = (32'(rd) << 7) | 32'(op);
    ok = 1'b0;
    w = 32'h0;
    case (ext)
      EXT_I: begin
        ok = (s >= -2048) && (s <= 2047);
        w = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | base;
      end
      EXT_U: begin
        ok = (imm % 4096) == 0;
        w = (imm & 32'hFFFFF000) | base;
      end
      EXT_S: begin
        ok = (s >= -2048) && (s <= 2047);
        w = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) |
            (32'(f3) << 12) | ((imm & 32'h1F) << 7) | 32'(op);
      end
      EXT_B: begin
        ok = (imm % 2 == 0) && (s >= -4096) && (s <= 4095);
        w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
            (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) |
            (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | 32'(op);
      end
      EXT_J: begin
        ok = (imm % 2 == 0) && (s >= -(64'sd1 << 20)) && (s < (64'sd1 << 20));
        w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
            (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | base;
      end
      EXT_ISH: begin
        ok = imm < 32;
        w = (32'(f7) << 25) | (imm << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | base;
      end
      EXT_R: begin
        ok = 1'b1;
        w = (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | base;
      end
      default: ok = 1'b0;
    endcase
    return {!ok, ok ? w : 32'h0};
  endfunction

  // Core immediate decoder, used for the round-trip property
  function automatic logic [31:0] decode(input logic [31:0] ins, input logic [2:0] ext);
    logic [31:0] v;
    case (ext)
      EXT_I:   v = sx(ins >> 20, 12);
      EXT_U:   v = ins & 32'hFFFFF000;
      EXT_S:   v = sx((((ins >> 25) & 32'h7F) << 5) | ((ins >> 7) & 32'h1F), 12);
      EXT_B:   v = sx((((ins >> 31) & 1) << 12) | (((ins >> 7) & 1) << 11) |
                      (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1), 13);
      EXT_J:   v = sx((((ins >> 31) & 1) << 20) | (((ins >> 12) & 32'hFF) << 12) |
                      (((ins >> 20) & 1) << 11) | (((ins >> 21) & 32'h3FF) << 1), 21);
      EXT_ISH: v = sx(ins >> 20, 12) & ~(32'h1 << 10);
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  // Compare process: scoreboard of accepted requests vs emitted results
  always @(negedge clk) begin
    exp_t e;
    logic [32:0] m;
    if (rst) begin
      q.delete();
      model_cnt = 0;
      hold = 1'b0;
    end else begin
      chk("err_cnt", 32'(err_cnt), model_cnt);
      if (hold) begin
        chk("stall valid", 32'(bus.out_valid), 32'd1);
        chk("stall instr", bus.out_instr, held_instr);
        chk("stall err", 32'(bus.out_err), 32'(held_err));
      end
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          e = q[0];
          chk("out_instr", bus.out_instr, e.instr);
          chk("out_err", 32'(bus.out_err), 32'(e.err));
          if (bus.out_ready) begin
            void'(q.pop_front());
            if (!e.err && e.ext != EXT_R && e.ext != EXT_RSV &&
                (e.ext != EXT_ISH || e.f7 == 7'h00 || e.f7 == 7'h20))
              chk("roundtrip", decode(bus.out_instr, e.ext), e.imm);
            if (e.err && model_cnt < (2 ** CNT_W) - 1) model_cnt++;
          end
        end
      end
      hold = bus.out_valid && !bus.out_ready;
      held_instr = bus.out_instr;
      held_err = bus.out_err;
      if (bus.in_valid && bus.in_ready) begin
        m = model_enc(bus.in_extOP, bus.in_opcode, bus.in_rd, bus.in_funct3,
                      bus.in_rs1, bus.in_rs2, bus.in_funct7, bus.in_imm);
        e.instr = m[31:0];
        e.err = m[32];
        e.ext = bus.in_extOP;
        e.f7 = bus.in_funct7;
        e.imm = bus.in_imm;
        q.push_back(e);
      end
    end
  end

  // Present one request and hold it until accepted (bounded)
  task automatic drive(input logic [2:0] ext, input logic [6:0] op, input logic [4:0] rd,
      input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [6:0] f7, input logic [31:0] imm);
    logic acc;
    int n;
    bus.in_extOP = ext; bus.in_opcode = op; bus.in_rd = rd; bus.in_funct3 = f3;
    bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_funct7 = f7; bus.in_imm = imm;
    bus.in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (!acc) chk("accept timeout", 32'd0, 32'd1);
  endtask

  // Single request with literal expectations on result, latency and counter
  task automatic send_check(input string name, input logic [2:0] ext, input logic [6:0] op,
      input logic [4:0] rd, input logic [2:0] f3, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] exp_instr,
      input logic exp_err, input int exp_cnt);
    int lat;
    drive(ext, op, rd, f3, rs1, rs2, 7'h0, imm);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 20);
    chk({name, " latency"}, lat, 2);
    chk({name, " instr"}, bus.out_instr, exp_instr);
    chk({name, " err"}, 32'(bus.out_err), 32'(exp_err));
    @(negedge clk);
    chk({name, " err_cnt"}, 32'(err_cnt), exp_cnt);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_imm(input logic [2:0] ext);
    logic [31:0] tbl [16];
    logic [31:0] r;
    tbl = '{32'd2047, -32'sd2048, 32'd2048, -32'sd2049, 32'd4094, -32'sd4096,
            32'd4096, -32'sd4098, 32'd1048574, -32'sd1048576, 32'd1048576,
            32'd31, 32'd32, 32'h1000, 32'h800, 32'd1};
    r = $urandom;
    if ($urandom_range(0, 99) < 10) return tbl[$urandom_range(0, 15)];
    if ($urandom_range(0, 99) < 15) return r;
    case (ext)
      EXT_I, EXT_S: return sx(r & 32'hFFF, 12);
      EXT_U:        return r & 32'hFFFFF000;
      EXT_B:        return sx(r & 32'h1FFE, 13);
      EXT_J:        return sx(r & 32'h1FFFFE, 21);
      EXT_ISH:      return r % 32;
      default:      return r;
    endcase
  endfunction

  bit rand_done;

  initial begin
    logic [32:0] pm;
    logic [2:0]  ext;
    logic [6:0]  f7;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_extOP = 3'h0; bus.in_opcode = 7'h0; bus.in_rd = 5'h0;
    bus.in_funct3 = 3'h0; bus.in_rs1 = 5'h0; bus.in_rs2 = 5'h0; bus.in_funct7 = 7'h0;
    bus.in_imm = 32'h0; bus.out_ready = 1'b1;

    // Model pins against hand-computed encodings
    pm = model_enc(EXT_I, OP_IMM, 5'd1, 3'd0, 5'd2, 5'd0, 7'd0, 32'hFFFFFFFF);
    chk("model I", pm[31:0], 32'hFFF10093);
    pm = model_enc(EXT_B, OP_BRANCH, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd8);
    chk("model B", pm[31:0], 32'h00208463);
    pm = model_enc(EXT_J, OP_JAL, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h800);
    chk("model J", pm[31:0], 32'h001000EF);
    pm = model_enc(EXT_I, OP_IMM, 5'd1, 3'd0, 5'd2, 5'd0, 7'd0, 32'h800);
    chk("model I err", 32'(pm[32]), 32'd1);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset out_instr", bus.out_instr, 32'h0);
    chk("reset out_err", 32'(bus.out_err), 32'd0);
    chk("reset err_cnt", 32'(err_cnt), 32'd0);
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed encodings and errors
    send_check("I", EXT_I, OP_IMM, 5'd1, 3'd0, 5'd2, 5'd0, 32'hFFFFFFFF, 32'hFFF10093, 1'b0, 0);
    send_check("B", EXT_B, OP_BRANCH, 5'd0, 3'd0, 5'd1, 5'd2, 32'd8, 32'h00208463, 1'b0, 0);
    send_check("J", EXT_J, OP_JAL, 5'd1, 3'd0, 5'd0, 5'd0, 32'h800, 32'h001000EF, 1'b0, 0);
    send_check("B odd", EXT_B, OP_BRANCH, 5'd0, 3'd0, 5'd1, 5'd2, 32'd7, 32'h0, 1'b1, 1);
    send_check("rsv", EXT_RSV, OP_IMM, 5'd3, 3'd0, 5'd1, 5'd2, 32'd0, 32'h0, 1'b1, 2);
    send_check("I range", EXT_I, OP_IMM, 5'd1, 3'd0, 5'd2, 5'd0, 32'h800, 32'h0, 1'b1, 3);

    // Backpressure: five back-to-back with the sink stalled four cycles
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          drive(EXT_I, OP_IMM, 5'(i + 1), 3'd0, 5'(i), 5'd0, 7'd0, 32'(i * 3));
      end
      begin
        repeat (2) @(negedge clk);
        @(negedge clk);
        chk("bp in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        chk("bp in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    repeat (5) @(posedge clk);
    #1;
    chk("bp drained", q.size(), 0);

    // Reset with both stages full
    bus.out_ready = 1'b0;
    drive(EXT_RSV, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
    drive(EXT_RSV, OP_IMM, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst err_cnt", 32'(err_cnt), 32'd0);
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst out_instr", bus.out_instr, 32'h0);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst no emit", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Randomized traffic with random sink stalls
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 2000; i++) begin
          ext = 3'($urandom_range(0, 7));
          f7 = 7'($urandom);
          if (ext == EXT_ISH && $urandom_range(0, 3) != 0) f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
          drive(ext, 7'($urandom), 5'($urandom), 3'($urandom), 5'($urandom),
                5'($urandom), f7, rand_imm(ext));
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 2) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("rand drained", q.size(), 0);

    // Counter saturation
    bus.out_ready = 1'b1;
    for (int i = 0; i < (2 ** CNT_W) + 3; i++)
      drive(EXT_RSV, OP_IMM, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("sat err_cnt", 32'(err_cnt), 32'h0000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1500000;
    miscompares++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule
